// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, CTRL bit
// positions and the controller state encoding.
package mmio_pkg;

   localparam logic [3:0] OFF_CTRL     = 4'd0;
   localparam logic [3:0] OFF_LOAD     = 4'd1;
   localparam logic [3:0] OFF_COUNT    = 4'd2;
   localparam logic [3:0] OFF_STATUS   = 4'd3;
   localparam logic [3:0] OFF_PRESCALE = 4'd4;

   localparam int CTRL_EN = 0;
   localparam int CTRL_AR = 1;
   localparam int CTRL_IE = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: counts 0..div while enabled and pulses tick on the wrap back to 0.
module tick_prescaler #(
   parameter int PRE_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [PRE_W-1:0] div,
   output logic             tick
);

   logic [PRE_W-1:0] pcnt;
   logic             wrap;

   // >= keeps the period sane if div is lowered below pcnt mid-run
   assign wrap = (pcnt >= div);
   assign tick = en & wrap;

   always_ff @(posedge clock) begin
      if (!reset) begin
         pcnt <= '0;
      end else if (clear) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= wrap ? '0 : pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with prescaler, one-shot/auto-reload and
// a registered interrupt; reads are registered to match syncram latency.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | stopped; COUNT and prescaler hold
//   ST_RUN  | prescaler running; COUNT decrements/reloads on each tick
module mmio_timer
   import mmio_pkg::*;
#(
   parameter logic [7:0] BASE  = 8'hFF,
   parameter int         PRE_W = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] address,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q,
   output logic        sel,
   output logic        irq
);

   state_t           state, state_nxt;
   logic [2:0]       ctrl;
   logic [31:0]      load;
   logic [31:0]      count;
   logic             expired;
   logic [PRE_W-1:0] prescale;
   logic             hit;
   logic [3:0]       off;
   logic             wr_ctrl, wr_load, wr_count, wr_status, wr_pre;
   logic             tick, expire, enter_run;
   logic [31:0]      rdata;

   assign hit       = (address[11:4] == BASE);
   assign off       = address[3:0];
   assign wr_ctrl   = hit & wren & (off == OFF_CTRL);
   assign wr_load   = hit & wren & (off == OFF_LOAD);
   assign wr_count  = hit & wren & (off == OFF_COUNT);
   assign wr_status = hit & wren & (off == OFF_STATUS);
   assign wr_pre    = hit & wren & (off == OFF_PRESCALE);

   // tick is only ever high in ST_RUN, since the prescaler is enabled there
   assign expire    = tick & (count == '0);
   assign enter_run = (state == ST_IDLE) & (state_nxt == ST_RUN);

   tick_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clock (clock),
      .reset (reset),
      .clear (enter_run),
      .en    (state == ST_RUN),
      .div   (prescale),
      .tick  (tick)
   );

   always_ff @(posedge clock) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // A software CTRL write overrides a one-shot expiry in the same cycle
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (wr_ctrl && data[CTRL_EN]) state_nxt = ST_RUN;
         ST_RUN: begin
            if (wr_ctrl)                        state_nxt = data[CTRL_EN] ? ST_RUN : ST_IDLE;
            else if (expire && !ctrl[CTRL_AR])  state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rdata = '0;
      case (off)
         OFF_CTRL:     rdata[2:0]       = ctrl;
         OFF_LOAD:     rdata            = load;
         OFF_COUNT:    rdata            = count;
         OFF_STATUS:   rdata[0]         = expired;
         OFF_PRESCALE: rdata[PRE_W-1:0] = prescale;
         default:      rdata            = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ctrl     <= '0;
         load     <= '0;
         count    <= '0;
         expired  <= 1'b0;
         prescale <= '0;
         q        <= '0;
         sel      <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (wr_ctrl)                          ctrl <= data[2:0];
         else if (expire && !ctrl[CTRL_AR])    ctrl[CTRL_EN] <= 1'b0;

         if (wr_load) load     <= data;
         if (wr_pre)  prescale <= data[PRE_W-1:0];

         if (wr_count)                         count <= data;
         else if (expire && ctrl[CTRL_AR])     count <= load;
         else if (tick && count != '0)         count <= count - 32'd1;

         if (expire)                           expired <= 1'b1;
         else if (wr_status && data[0])        expired <= 1'b0;

         q   <= hit ? rdata : '0;
         sel <= hit;
         irq <= expired & ctrl[CTRL_IE];
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: the driver queues hand-computed read results,
// a monitor pops and compares them one cycle after each checked access.
module tb_mmio_timer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] address = '0;
   logic [31:0] data = '0;
   logic        wren = 1'b0;
   logic [31:0] q;
   logic        sel;
   logic        irq;

   localparam logic [11:0] BA = 12'hFF0;

   typedef struct {
      int          id;
      logic        sel;
      logic [31:0] q;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   bit   chk_now = 1'b0;
   bit   pend;
   int   step = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   mmio_timer dut (
      .clock   (clock),
      .reset   (reset),
      .address (address),
      .data    (data),
      .wren    (wren),
      .q       (q),
      .sel     (sel),
      .irq     (irq)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      pend = chk_now;
      #1;
      if (pend) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: output presented with no expected entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (sel !== e.sel) begin
               n_errors++;
               $display("FAIL sel step %0d: got %b expected %b", e.id, sel, e.sel);
            end
            n_checks++;
            if (q !== e.q) begin
               n_errors++;
               $display("FAIL q step %0d: got %h expected %h", e.id, q, e.q);
            end
            n_checks++;
            if (irq !== e.irq) begin
               n_errors++;
               $display("FAIL irq step %0d: got %b expected %b", e.id, irq, e.irq);
            end
         end
      end
   end

   task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic we,
                      input bit chk, input logic es, input logic [31:0] eq, input logic ei);
      exp_t e;
      address = a;
      data    = d;
      wren    = we;
      chk_now = chk;
      if (chk) begin
         e.id  = step;
         e.sel = es;
         e.q   = eq;
         e.irq = ei;
         exp_q.push_back(e);
      end
      step++;
      @(negedge clock);
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      cyc(BA | {8'h00, off}, d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic rd(input logic [3:0] off, input logic [31:0] eq, input logic ei);
      cyc(BA | {8'h00, off}, 32'h0, 1'b0, 1'b1, 1'b1, eq, ei);
   endtask

   task automatic idle();
      cyc(12'h000, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      @(negedge clock);
      // bus writes while in reset are ignored and outputs stay cleared
      cyc(BA | 12'h0, 32'h7, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(BA | 12'h1, 32'h1234, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) rd(i[3:0], 32'h0, 1'b0);

      // one-shot with irq, prescale 0
      wr(4, 0); wr(2, 3); wr(0, 5);
      rd(2, 3, 0); rd(2, 2, 0); rd(2, 1, 0); rd(2, 0, 0);
      rd(3, 1, 1); rd(0, 4, 1); rd(2, 0, 1); rd(2, 0, 1);
      wr(3, 1); rd(3, 0, 0); wr(0, 0);

      // auto-reload, prescale 1: expiry every 6 cycles
      wr(1, 2); wr(2, 0); wr(4, 1); wr(0, 3);
      rd(2, 0, 0); rd(2, 0, 0);
      rd(2, 2, 0); rd(2, 2, 0); rd(2, 1, 0); rd(2, 1, 0); rd(2, 0, 0); rd(2, 0, 0);
      rd(2, 2, 0); rd(2, 2, 0);
      rd(3, 1, 0); wr(3, 1); rd(3, 0, 0);
      wr(3, 1);                  // coincides with an expiry: flag must stay set
      rd(3, 1, 0);
      wr(2, 32'h10);             // coincides with a tick: write wins
      rd(2, 32'h10, 0); rd(2, 32'h10, 0); rd(2, 32'hF, 0);
      wr(0, 0);
      rd(2, 32'hE, 0); rd(2, 32'hE, 0);
      wr(3, 1);

      // misses and unused offsets
      cyc(12'h7F2, 32'h55, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(12'h7F2, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      wr(7, 32'hFFFF_FFFF);
      rd(7, 0, 0); rd(2, 32'hE, 0); rd(0, 0, 0); rd(3, 0, 0);

      // reset pulse mid-count
      wr(4, 3); wr(2, 5); wr(0, 5);
      rd(2, 5, 0); rd(0, 5, 0);
      reset = 1'b0;
      cyc(BA | 12'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      rd(0, 0, 0); rd(2, 0, 0); rd(4, 0, 0); rd(3, 0, 0);
      repeat (8) idle();
      rd(2, 0, 0); rd(3, 0, 0);

      chk_now = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
